// File: rtl/tl_rr_arbiter.sv
// tl_rr_arbiter
// Drains four show-ahead virtual-channel FIFOs into one downstream stream.
// One FIFO is granted at a time, in round-robin order, for a burst of at most
// MAX_BURST consecutive pops. The popped word and its source index are
// registered toward the link-layer FIFO. Downstream almost-full stalls popping.
//
// Build option: define TL_ARB_STRICT_PRIO_EN to replace round-robin with fixed
// priority (FIFO0 highest); burst limit and inter-burst gaps are unchanged.
//
// Ports:
//   clk                    single clock, rising edge
//   rst_n                  synchronous reset, ACTIVE-HIGH (name kept for compatibility)
//   request                drain enable, sampled every cycle
//   empty0..empty3         FIFO N empty flag
//   data_out0..data_out3   FIFO N head word (valid while emptyN=0)
//   out_afull              downstream almost-full (>=1 free slot while high)
//   pop0..pop3             combinational pop to FIFO N
//   out_push               registered downstream write strobe
//   out_data               registered word ([9:8] class, [7:0] payload, untouched)
//   out_src                registered source FIFO index of out_data
//   busy                   registered, high while in SERVE
module tl_rr_arbiter #(
  parameter int DATA_W    = 10,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              request,
  input  logic              empty0,
  input  logic              empty1,
  input  logic              empty2,
  input  logic              empty3,
  input  logic [DATA_W-1:0] data_out0,
  input  logic [DATA_W-1:0] data_out1,
  input  logic [DATA_W-1:0] data_out2,
  input  logic [DATA_W-1:0] data_out3,
  input  logic              out_afull,
  output logic              pop0,
  output logic              pop1,
  output logic              pop2,
  output logic              pop3,
  output logic              out_push,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  output logic              busy
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t            state, state_nx;
  logic [1:0]        grant, grant_nx;
  logic [1:0]        last_grant, last_grant_nx;
  logic [3:0]        burst_cnt, burst_cnt_nx;

  logic [3:0]        empty_v;
  logic              any_ready;
  logic [1:0]        pick;
  logic              found;
  logic [1:0]        idx;
  logic              pop_fire;
  logic [3:0]        pop_v;
  logic [DATA_W-1:0] head;

  assign empty_v   = {empty3, empty2, empty1, empty0};
  assign any_ready = ~&empty_v;

  // Arbitration: first non-empty FIFO in scan order.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
`ifdef TL_ARB_STRICT_PRIO_EN
    for (int unsigned i = 0; i < 4; i++) begin
      idx = 2'(i);
      if (!found && !empty_v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
`else
    // Offsets 1..4 from last_grant; offset 4 wraps back onto last_grant itself.
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last_grant + 2'(i);
      if (!found && !empty_v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
`endif
  end

  // State register and output registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= 2'd3;
      burst_cnt  <= '0;
      out_push   <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_grant <= last_grant_nx;
      burst_cnt  <= burst_cnt_nx;
      out_push   <= pop_fire;
      if (pop_fire) begin
        out_data <= head;
        out_src  <= grant;
      end
      busy       <= (state_nx == SERVE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    last_grant_nx = last_grant;
    burst_cnt_nx  = burst_cnt;
    unique case (state)
      IDLE: begin
        if (request && any_ready) begin
          grant_nx      = pick;
          last_grant_nx = pick;
          burst_cnt_nx  = '0;
          state_nx      = SERVE;
        end
      end
      SERVE: begin
        if (!request) begin
          state_nx = IDLE;
        end else if (empty_v[grant]) begin
          state_nx = IDLE;
        end else if (!out_afull) begin
          burst_cnt_nx = burst_cnt + 4'd1;
          if (burst_cnt == 4'(MAX_BURST - 1)) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: one-hot pop toward the granted FIFO, head word mux.
  always_comb begin
    pop_fire = (state == SERVE) & request & ~empty_v[grant] & ~out_afull & ~rst_n;
    pop_v    = pop_fire ? (4'b0001 << grant) : 4'b0000;
    pop0     = pop_v[0];
    pop1     = pop_v[1];
    pop2     = pop_v[2];
    pop3     = pop_v[3];
    unique case (grant)
      2'd0:    head = data_out0;
      2'd1:    head = data_out1;
      2'd2:    head = data_out2;
      default: head = data_out3;
    endcase
  end

endmodule

// File: tb/tb_tl_rr_arbiter.sv
// Testbench for tl_rr_arbiter: behavioural show-ahead FIFO models feed the DUT,
// a transaction-level model predicts the (src, data) order of the drained
// stream into a scoreboard queue, and a monitor compares every out_push.
module tb_tl_rr_arbiter;
  localparam int DATA_W    = 10;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              rst_n, request, out_afull;
  logic              empty0, empty1, empty2, empty3;
  logic [DATA_W-1:0] data_out0, data_out1, data_out2, data_out3;
  logic              pop0, pop1, pop2, pop3;
  logic              out_push, busy;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_src;

  tl_rr_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .request(request),
    .empty0(empty0), .empty1(empty1), .empty2(empty2), .empty3(empty3),
    .data_out0(data_out0), .data_out1(data_out1),
    .data_out2(data_out2), .data_out3(data_out3),
    .out_afull(out_afull),
    .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
    .out_push(out_push), .out_data(out_data), .out_src(out_src), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pop_cnt [4];

  logic [DATA_W-1:0] q0[$], q1[$], q2[$], q3[$];
  logic [11:0]       expq[$];
  int                pc[$];
  int                ps[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int fsize(input int n);
    case (n)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] fat(input int n, input int i);
    case (n)
      0: return q0[i];
      1: return q1[i];
      2: return q2[i];
      default: return q3[i];
    endcase
  endfunction

  task automatic refresh();
    empty0 = (q0.size() == 0); data_out0 = empty0 ? 10'h3AA : q0[0];
    empty1 = (q1.size() == 0); data_out1 = empty1 ? 10'h3AA : q1[0];
    empty2 = (q2.size() == 0); data_out2 = empty2 ? 10'h3AA : q2[0];
    empty3 = (q3.size() == 0); data_out3 = empty3 ? 10'h3AA : q3[0];
  endtask

  task automatic fpush(input int n, input logic [DATA_W-1:0] d);
    case (n)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      default: q3.push_back(d);
    endcase
    refresh();
  endtask

  task automatic fpop(input int n);
    case (n)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      2: void'(q2.pop_front());
      default: void'(q3.pop_front());
    endcase
  endtask

  function automatic logic [DATA_W-1:0] word(input int n, input int k);
    return {2'(n), 4'(n + 1), 4'(2 * n + k)};
  endfunction

  // Reference: drain the current FIFO contents burst by burst, each burst
  // taking min(MAX_BURST, occupancy) words from the arbitration winner.
  task automatic predict(input int last_in, output int last_out);
    int len [4];
    int hd  [4];
    int last, pick, n, left;
    last = last_in;
    left = 0;
    for (int i = 0; i < 4; i++) begin
      len[i] = fsize(i);
      hd[i]  = 0;
      left  += len[i];
    end
    while (left > 0) begin
      pick = -1;
`ifdef TL_ARB_STRICT_PRIO_EN
      for (int i = 0; i < 4; i++)
        if (pick < 0 && hd[i] < len[i]) pick = i;
`else
      for (int i = 1; i <= 4; i++)
        if (pick < 0 && hd[(last + i) % 4] < len[(last + i) % 4]) pick = (last + i) % 4;
`endif
      n = len[pick] - hd[pick];
      if (n > MAX_BURST) n = MAX_BURST;
      for (int k = 0; k < n; k++) begin
        expq.push_back({2'(pick), fat(pick, hd[pick])});
        hd[pick]++;
      end
      left -= n;
      last  = pick;
    end
    last_out = last;
  endtask

  // FIFO models: consume the head on a pop seen at the edge.
  always @(posedge clk) begin
    logic [3:0] pv;
    logic       af, rs;
    pv = {pop3, pop2, pop1, pop0};
    af = out_afull;
    rs = rst_n;
    cyc++;
    #1;
    if (pv != 4'b0) begin
      chk("pop_legal", int'($onehot(pv) && !af && !rs), 1);
      for (int n = 0; n < 4; n++) begin
        if (pv[n]) begin
          if (fsize(n) == 0) chk("pop_on_empty", n, -1);
          else begin
            fpop(n);
            pop_cnt[n]++;
          end
        end
      end
      refresh();
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [11:0] e;
    if (out_push === 1'b1) begin
      pc.push_back(cyc);
      ps.push_back(int'(out_src));
      if (expq.size() == 0) chk("unexpected_push", 1, 0);
      else begin
        e = expq.pop_front();
        chk("out_src", int'(out_src), int'(e[11:10]));
        chk("out_data", int'(out_data), int'(e[9:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    pc.delete();
    ps.delete();
    for (int i = 0; i < 4; i++) pop_cnt[i] = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    clear_logs();
  endtask

  task automatic drain(input int budget, input bit rnd_afull);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      if (rnd_afull) out_afull = ($urandom_range(0, 3) == 0);
      step();
      if (q0.size() + q1.size() + q2.size() + q3.size() == 0 &&
          expq.size() == 0 && !busy && !out_push) done = 1'b1;
    end
    out_afull = 1'b0;
    if (!done) begin
      chk("drain_timeout", 0, 1);
      expq.delete();
    end
    step();
  endtask

  task automatic wait_pops(input int n, input int cnt);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      step();
      if (pop_cnt[n] >= cnt) ok = 1'b1;
    end
    chk("wait_pops_timeout", int'(ok), 1);
  endtask

  initial begin
    int last;
    int exp_src [12];
    rst_n = 1'b1; request = 1'b1; out_afull = 1'b0;
    for (int n = 0; n < 4; n++) pop_cnt[n] = 0;
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 2; k++) fpush(n, word(n, k));
    refresh();

    // Reset held two cycles with every FIFO non-empty and request high.
    for (int r = 0; r < 2; r++) begin
      step();
      chk("rst_pops", int'({pop3, pop2, pop1, pop0}), 0);
      chk("rst_out_push", int'(out_push), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_src", int'(out_src), 0);
      chk("rst_busy", int'(busy), 0);
    end
    chk("rst_no_pops", pop_cnt[0] + pop_cnt[1] + pop_cnt[2] + pop_cnt[3], 0);

    // Two words per FIFO: src order 0,0,1,1,2,2,3,3 with 2 idle cycles between sources.
    clear_logs();
    predict(3, last);
    rst_n = 1'b0;
    drain(200, 1'b0);
    chk("rr_count", pc.size(), 8);
    for (int i = 1; i < pc.size(); i++)
      chk("rr_gap", pc[i] - pc[i-1], (ps[i] == ps[i-1]) ? 1 : 3);

    // Seven words in FIFO0 only: burst of 4, one idle cycle, burst of 3.
    do_reset();
    for (int k = 0; k < 7; k++) fpush(0, 10'(32'h101 + k));
    predict(3, last);
    drain(200, 1'b0);
    chk("f0_pop_count", pop_cnt[0], 7);
    chk("f0_push_count", pc.size(), 7);
    for (int i = 1; i < pc.size(); i++)
      chk("f0_gap", pc[i] - pc[i-1], (i == 4) ? 2 : 1);

    // Almost-full for 3 cycles after the 2nd pop of a FIFO2 burst.
    do_reset();
    for (int k = 0; k < 6; k++) fpush(2, 10'(32'h200 + k));
    predict(3, last);
    wait_pops(2, 2);
    out_afull = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("afull_no_pop", int'(pop2), 0);
    end
    chk("afull_held_count", pop_cnt[2], 2);
    out_afull = 1'b0;
    drain(200, 1'b0);
    chk("afull_push_count", pc.size(), 6);
    if (pc.size() == 6) begin
      chk("afull_gap1", pc[1] - pc[0], 1);
      chk("afull_gap_stall", pc[2] - pc[1], 4);
      chk("afull_gap3", pc[3] - pc[2], 1);
      chk("afull_burst_end", pc[4] - pc[3], 2);
    end

    // request dropped mid-burst of FIFO1; re-arbitration resumes at FIFO2.
    do_reset();
    for (int k = 0; k < 4; k++) fpush(1, 10'(32'h140 + k));
    expq.push_back({2'd1, 10'h140});
    expq.push_back({2'd1, 10'h141});
    wait_pops(1, 2);
    request = 1'b0;
    #1;
    chk("req_drop_pop_same_cycle", int'({pop3, pop2, pop1, pop0}), 0);
    step();
    step();
    chk("req_drop_pop_count", pop_cnt[1], 2);
    chk("req_drop_busy", int'(busy), 0);
    for (int n = 0; n < 4; n++)
      if (n != 1) for (int k = 0; k < 2; k++) fpush(n, word(n, k));
    predict(1, last);
    request = 1'b1;
    drain(300, 1'b0);
    chk("req_resume_count", pc.size(), 10);
    if (pc.size() > 2) chk("req_resume_first_src", ps[2], 2);

    // FIFO0 and FIFO3 with 6 words each.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      fpush(0, 10'(32'h010 + k));
      fpush(3, 10'(32'h330 + k));
    end
    predict(3, last);
    drain(300, 1'b0);
`ifdef TL_ARB_STRICT_PRIO_EN
    exp_src = '{0, 0, 0, 0, 0, 0, 3, 3, 3, 3, 3, 3};
`else
    exp_src = '{0, 0, 0, 0, 3, 3, 3, 3, 0, 0, 3, 3};
`endif
    chk("prio_push_count", pc.size(), 12);
    if (pc.size() == 12)
      for (int i = 0; i < 12; i++) chk("prio_src_order", ps[i], exp_src[i]);

    // Randomized fills with random backpressure; arbitration state carries over.
    do_reset();
    last = 3;
    for (int it = 0; it < 20; it++) begin
      for (int n = 0; n < 4; n++) begin
        int sz;
        sz = $urandom_range(0, 9);
        for (int k = 0; k < sz; k++) fpush(n, 10'($urandom));
      end
      predict(last, last);
      drain(600, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
